// File: rtl/alu_result_formatter_pkg.sv
// Shared definitions for the ALU result formatter: opcodes, FSM states and
// conversion lengths.
package alu_result_formatter_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [4:0] MUL_LEN = 5'd16;
    localparam logic [4:0] DIV_LEN = 5'd8;
    localparam logic [4:0] MUL_LAST = MUL_LEN - 5'd1;
    localparam logic [4:0] DIV_LAST = DIV_LEN - 5'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV_A,
        S_CONV_B,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_result_formatter_if.sv
// Request/result bundle between an ALU-side requester and the formatter.
interface alu_result_formatter_if;
    logic        start;
    logic [15:0] result;
    logic [1:0]  op;
    logic        status;
    logic [19:0] digits;
    logic [11:0] rem_digits;
    logic        neg;
    logic        ovf;
    logic        err;
    logic        busy;
    logic        done;

    modport master (
        output start, result, op, status,
        input  digits, rem_digits, neg, ovf, err, busy, done
    );

    modport slave (
        input  start, result, op, status,
        output digits, rem_digits, neg, ovf, err, busy, done
    );
endinterface

// File: rtl/alu_result_formatter_bin2bcd_step.sv
// One double-dabble step: add-3 to every BCD digit >= 5, then shift in one bit.
module bin2bcd_step (
    input  logic [19:0] bcd_in,
    input  logic        bit_in,
    output logic [19:0] bcd_out
);
    logic [15:0] adj;
    logic [2:0]  top_adj;

    always_comb begin
        adj = bcd_in[15:0];
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
        // Top digit's MSB is shifted out, so only its low 3 bits are kept.
        top_adj = (bcd_in[19:16] >= 4'd5) ? (bcd_in[18:16] + 3'd3) : bcd_in[18:16];
        bcd_out = {top_adj, adj, bit_in};
    end
endmodule

// File: rtl/alu_result_formatter.sv
// Formats ALU results as BCD digits: direct packing for add/sub, serial
// double-dabble conversion for mul and div (quotient, then remainder).
module alu_result_formatter
    import alu_result_formatter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    alu_result_formatter_if.slave bus
);
    state_t      state, state_next;
    logic [15:0] cap_result;
    logic [1:0]  cap_op;
    logic        cap_status;
    logic [15:0] sr;
    logic [19:0] acc, step_out;
    logic [11:0] quo;
    logic [4:0]  cnt;
    logic        last_a, last_b;

    logic [19:0] digits_r;
    logic [11:0] rem_r;
    logic        neg_r, ovf_r, err_r, busy_r, done_r;

    bin2bcd_step u_step (
        .bcd_in  (acc),
        .bit_in  (sr[15]),
        .bcd_out (step_out)
    );

    assign last_a = (cnt == ((cap_op == OP_MUL) ? MUL_LAST : DIV_LAST));
    assign last_b = (cnt == DIV_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (bus.start) state_next = S_LOAD;
            S_LOAD:   state_next = (cap_op == OP_MUL || (cap_op == OP_DIV && !cap_status))
                                   ? S_CONV_A : S_DONE;
            S_CONV_A: if (last_a) state_next = (cap_op == OP_DIV) ? S_CONV_B : S_DONE;
            S_CONV_B: if (last_b) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cap_result <= '0;
            cap_op     <= '0;
            cap_status <= 1'b0;
            sr         <= '0;
            acc        <= '0;
            quo        <= '0;
            cnt        <= '0;
            digits_r   <= '0;
            rem_r      <= '0;
            neg_r      <= 1'b0;
            ovf_r      <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= (state == S_DONE);
            busy_r <= (state_next == S_LOAD) || (state_next == S_CONV_A) || (state_next == S_CONV_B);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        cap_result <= bus.result;
                        cap_op     <= bus.op;
                        cap_status <= bus.status;
                    end
                end
                S_LOAD: begin
                    acc <= '0;
                    cnt <= '0;
                    sr  <= (cap_op == OP_MUL) ? cap_result : {cap_result[7:0], 8'h00};
                    if (state_next == S_DONE) begin
                        rem_r <= '0;
                        ovf_r <= 1'b0;
                        neg_r <= (cap_op == OP_SUB) && cap_status;
                        err_r <= (cap_op == OP_DIV);
                        case (cap_op)
                            OP_ADD:  digits_r <= {8'h00, 3'b000, cap_status, cap_result[7:0]};
                            OP_SUB:  digits_r <= {12'h000, cap_result[7:0]};
                            default: digits_r <= '0;
                        endcase
                    end
                end
                S_CONV_A: begin
                    acc <= step_out;
                    sr  <= {sr[14:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (last_a) begin
                        if (cap_op == OP_DIV) begin
                            // Park the quotient digits and restart on the remainder.
                            quo <= step_out[11:0];
                            acc <= '0;
                            cnt <= '0;
                            sr  <= {cap_result[15:8], 8'h00};
                        end else begin
                            digits_r <= step_out;
                            rem_r    <= '0;
                            neg_r    <= 1'b0;
                            err_r    <= 1'b0;
                            ovf_r    <= (cap_result[15:8] != 8'h00);
                        end
                    end
                end
                S_CONV_B: begin
                    acc <= step_out;
                    sr  <= {sr[14:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (last_b) begin
                        digits_r <= {8'h00, quo};
                        rem_r    <= step_out[11:0];
                        neg_r    <= 1'b0;
                        ovf_r    <= 1'b0;
                        err_r    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.digits     = digits_r;
    assign bus.rem_digits = rem_r;
    assign bus.neg        = neg_r;
    assign bus.ovf        = ovf_r;
    assign bus.err        = err_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_alu_result_formatter.sv
// Self-checking bench for alu_result_formatter: directed vectors, reset and
// ignored-start cases, then randomized ops against a decimal reference model.
module tb_alu_result_formatter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [19:0] prev_digits = '0;

    always #5 clk = ~clk;

    alu_result_formatter_if bus ();

    alu_result_formatter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [15:0] res, input logic st, input bit poke);
        logic [19:0] exp_d, rb;
        logic [11:0] exp_r;
        logic exp_neg, exp_ovf, exp_err;
        int unsigned lat, got, busy_n;
        exp_r = '0; exp_neg = 0; exp_ovf = 0; exp_err = 0;
        case (op)
            2'd0: begin exp_d = {8'h00, 3'b000, st, res[7:0]}; lat = 2; end
            2'd1: begin exp_d = {12'h000, res[7:0]}; exp_neg = st; lat = 2; end
            2'd2: begin exp_d = to_bcd(res); exp_ovf = (res > 16'd255); lat = 18; end
            default: begin
                if (st) begin
                    exp_d = '0; exp_err = 1; lat = 2;
                end else begin
                    exp_d = to_bcd(res[7:0]);
                    rb = to_bcd(res[15:8]);
                    exp_r = rb[11:0];
                    lat = 18;
                end
            end
        endcase

        @(negedge clk);
        bus.start = 1; bus.op = op; bus.result = res; bus.status = st;
        @(posedge clk); #1;
        bus.start = 0; bus.op = 2'($urandom); bus.result = 16'($urandom); bus.status = 1'($urandom);
        got = 0; busy_n = 0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                if (poke && k == 3) begin
                    bus.start = 1; bus.op = 2'd0; bus.result = 16'h0011; bus.status = 0;
                end
                if (poke && k == 4) bus.start = 0;
                @(posedge clk); #1;
            end
            if (bus.done) begin got = k; break; end
            if (bus.busy) begin
                busy_n++;
                check("hold", bus.digits, prev_digits);
            end
        end
        check("latency", got, lat);
        check("busy_cycles", busy_n, lat - 1);
        check("digits", bus.digits, exp_d);
        check("rem", bus.rem_digits, exp_r);
        check("neg", bus.neg, exp_neg);
        check("ovf", bus.ovf, exp_ovf);
        check("err", bus.err, exp_err);
        check("busy_at_done", bus.busy, 0);
        @(posedge clk); #1;
        check("done_pulse", bus.done, 0);
        check("digits_held", bus.digits, exp_d);
        prev_digits = exp_d;
    endtask

    task automatic reset_mid_mul();
        bit seen;
        @(negedge clk);
        bus.start = 1; bus.op = 2'd2; bus.result = 16'hFE01; bus.status = 1;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_digits", bus.digits, 0);
        check("rst_rem", bus.rem_digits, 0);
        check("rst_flags", {bus.neg, bus.ovf, bus.err}, 0);
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1;
        end
        check("rst_no_done", seen, 0);
        prev_digits = '0;
    endtask

    initial begin
        logic [1:0]  op;
        logic [15:0] res;
        logic        st;
        bus.start = 0; bus.op = '0; bus.result = '0; bus.status = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", bus.digits, 0);
        check("reset_rem", bus.rem_digits, 0);
        check("reset_flags", {bus.neg, bus.ovf, bus.err, bus.busy, bus.done}, 0);
        rst = 0;

        run_op(2'd0, 16'h0082, 0, 0);
        run_op(2'd0, 16'h0098, 1, 0);
        run_op(2'd1, 16'h0045, 1, 0);
        run_op(2'd2, 16'hFE01, 1, 0);
        run_op(2'd3, 16'h041C, 0, 0);
        run_op(2'd3, 16'h1234, 1, 0);
        run_op(2'd2, 16'h00FF, 0, 1);
        run_op(2'd3, 16'hFFFF, 0, 1);
        reset_mid_mul();
        run_op(2'd1, 16'h0099, 0, 0);

        for (int n = 0; n < 30; n++) begin
            op  = 2'($urandom_range(0, 3));
            res = 16'($urandom);
            st  = (op == 2'd3) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            run_op(op, res, st, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_result_formatter.md
ALU_RESULT_FORMATTER -- requirements
Module: alu_result_formatter

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 start  in  1  one-cycle request; samples result/op/status in the same cycle.
REQ-004 result  in  16  ALU output: BCD sum/diff in [7:0] (add/sub), binary product (mul), {remainder, quotient} (div).
REQ-005 op  in  2  ALU opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 status  in  1  ALU status: carry, borrow, overflow or divide-by-zero.
REQ-007 digits  out  20  five BCD digits, most significant digit in [19:16].
REQ-008 rem_digits  out  12  three BCD digits of the division remainder; zero for other ops.
REQ-009 neg  out  1  subtraction borrow flag, i.e. displayed value is negative.
REQ-010 ovf  out  1  multiply product exceeds 255.
REQ-011 err  out  1  divide-by-zero.
REQ-012 busy  out  1  high from the cycle after an accepted start until done.
REQ-013 done  out  1  one-cycle pulse; outputs are valid and held until the next accepted start.

Function
REQ-014 Start acceptance: start is accepted only in IDLE; start while busy or in DONE is ignored.
REQ-015 FSM states:
- IDLE: on start, go to LOAD.
- LOAD: go to CONV_A for mul or div-nonzero; otherwise go to DONE.
- CONV_A: after the last shift, go to CONV_B for div, otherwise to DONE.
- CONV_B: after 8 shifts, go to DONE.
- DONE: return to IDLE.
REQ-016 Latency: with start accepted at edge N, done is high for exactly the one cycle following edge N+L.
- L = 2 for add, sub and div-by-zero.
- L = 18 for mul.
- L = 18 for div.
REQ-017 Add: digits = {8'h00, 3'b000, status, result[7:0]}, giving the range 000–198; neg=0.
REQ-018 Sub: digits = {12'h000, result[7:0]}; neg = status.
REQ-019 Mul conversion: 16-bit binary to 5-digit BCD by double-dabble. Each CONV_A cycle applies add-3 to every digit ≥5, then shifts one bit in MSB first; 16 cycles total. ovf = (result[15:8] != 0).
REQ-020 Div conversion (status=0): CONV_A converts result[7:0] (quotient) in 8 cycles into digits[11:0], with digits[19:12]=0. CONV_B converts result[15:8] (remainder) in 8 cycles into rem_digits.
REQ-021 Div by zero (status=1): err=1, digits=0, rem_digits=0, no conversion.
REQ-022 Output update: digits, rem_digits, neg, ovf and err update only at entry to DONE; they are stable during busy.
REQ-023 Input capture: inputs are captured at acceptance; later changes to result/op/status do not affect the conversion in progress.
REQ-024 Width rule: BCD digits never exceed 9 at done; maximum mul input 0xFE01 → 0x65025.

Reset
REQ-025 rst returns the FSM to IDLE in the next cycle and clears all outputs, the shift register and the counters to 0; this holds mid-conversion too.
REQ-026 rst has priority over start when both are asserted in the same cycle.

Structure
REQ-027 Shared package contents:
- opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV);
- the FSM state enum;
- conversion lengths (16, 8).
REQ-028 One sub-module, bin2bcd_step: combinational add-3 correction plus 1-bit shift of a 20-bit BCD accumulator, instantiated once and reused for CONV_A and CONV_B.
REQ-029 The shift counter is 5 bits wide; no other arithmetic beyond the add-3 correction.

Verification
REQ-030 Add: op=00, result=0x0082, status=0 → done at N+2, digits=0x00082, neg=0.
REQ-031 Add with carry: op=00, result=0x0098, status=1 → digits=0x00198.
REQ-032 Mul: op=10, result=0xFE01, status=1 → busy for 17 cycles, done at N+18, digits=0x65025, ovf=1.
REQ-033 Div 200/7: op=11, result=0x041C, status=0 → digits=0x00028, rem_digits=0x004, done at N+18. Div by zero: status=1 → err=1, digits=0, done at N+2.
REQ-034 Reset and ignored start:
- rst asserted 5 cycles into a mul → next cycle busy=0, all outputs 0, no done pulse.
- start re-asserted while busy → ignored; the first result completes unchanged.
